// File: rtl/mem_port_arbiter_if.sv
// Shared-memory port bundle: fetch and data requesters plus the
// single-port memory command/response path.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_ready, mem_rdata,
    output if_ack, if_rdata, if_stall,
    output dm_ack, dm_rdata, dm_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_ready, mem_rdata,
    input  if_ack, if_rdata, if_stall,
    input  dm_ack, dm_rdata, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port memory; one transaction
// in flight, data side preferred with a starvation cap for fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_starve;
  logic        r_own_dm;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_if_ack;
  logic        r_dm_ack;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic w_starved;
  logic w_grant_dm;
  logic w_grant_if;

  // Fetch only overrides data once it has lost STARVE_MAX times in a row.
  assign w_starved  = (r_starve == 4'(STARVE_MAX));
  assign w_grant_dm = bus.dm_req & ~(bus.if_req & w_starved);
  assign w_grant_if = bus.if_req & ~w_grant_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_own_dm    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_dm | w_grant_if) begin
            r_state     <= ISSUE;
            r_mem_req   <= 1'b1;
            r_own_dm    <= w_grant_dm;
            r_mem_we    <= w_grant_dm & bus.dm_we;
            r_mem_addr  <= w_grant_dm ? bus.dm_addr : bus.if_addr;
            r_mem_wdata <= w_grant_dm ? bus.dm_wdata : '0;
            if (w_grant_if)
              r_starve <= '0;
            else if (bus.if_req)
              r_starve <= r_starve + 4'd1;
          end
        end
        ISSUE: begin
          r_mem_req <= 1'b0;
          r_state   <= WAIT;
        end
        WAIT: begin
          if (bus.mem_ready) begin
            r_state <= RESP;
            if (r_own_dm) begin
              r_dm_rdata <= bus.mem_rdata;
              r_dm_ack   <= 1'b1;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_ack    = r_if_ack;
  assign bus.dm_ack    = r_dm_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rdata  = r_dm_rdata;
  assign bus.if_stall  = bus.if_req & ~r_if_ack;
  assign bus.dm_stall  = bus.dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level
// model; directed scenarios cover latency, priority, starvation, reset.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          m_out = 0;
  bit          m_own_dm = 0;
  int          m_ready_c = 0;
  int          m_ack_c = 0;
  int          m_free_from = 0;
  int          m_starve = 0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_dm_rd = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          m_we = 0;
  logic [31:0] m_ret = '0;
  int          last_issue_c = -1;
  int          last_ack_c = -1;

  int          fix_lat = 0;
  bit          ret_fix = 0;
  logic [31:0] ret_val = '0;
  int          g_log[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: sample at negedge, compare with model, drive memory side.
  task automatic tick();
    bit idle_prev;
    bit exp_req;
    bit gdm;
    bit exp_ia;
    bit exp_da;
    int lat;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_ack", bus.if_ack, 0);
      chk("rst_dm_ack", bus.dm_ack, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_dm_rdata", bus.dm_rdata, 0);
      m_out = 0;
      m_starve = 0;
      m_if_rd = '0;
      m_dm_rd = '0;
      m_free_from = cyc;
    end else begin
      idle_prev = !m_out && (cyc - 1 >= m_free_from);
      exp_req = idle_prev && (bus.if_req || bus.dm_req);
      chk("mem_req", bus.mem_req, exp_req);
      if (bus.mem_req) g_log.push_back(int'(bus.mem_we));
      if (exp_req) begin
        gdm = bus.dm_req && !(bus.if_req && m_starve == SM);
        if (gdm) begin
          if (bus.if_req) m_starve++;
          m_addr = bus.dm_addr;
          m_we = bus.dm_we;
          m_wdata = bus.dm_wdata;
        end else begin
          m_starve = 0;
          m_addr = bus.if_addr;
          m_we = 0;
          m_wdata = '0;
        end
        lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 8));
        m_own_dm = gdm;
        m_out = 1;
        m_ready_c = cyc + lat;
        m_ack_c = cyc + lat + 1;
        last_issue_c = cyc;
      end
      if (m_out && cyc <= m_ready_c) begin
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_we", bus.mem_we, m_we);
        if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      exp_ia = m_out && !m_own_dm && cyc == m_ack_c;
      exp_da = m_out && m_own_dm && cyc == m_ack_c;
      chk("if_ack", bus.if_ack, exp_ia);
      chk("dm_ack", bus.dm_ack, exp_da);
      if (m_out && cyc == m_ack_c) begin
        if (m_own_dm) m_dm_rd = m_ret;
        else m_if_rd = m_ret;
        m_out = 0;
        m_free_from = cyc + 1;
        last_ack_c = cyc;
      end
      chk("if_rdata", bus.if_rdata, m_if_rd);
      chk("dm_rdata", bus.dm_rdata, m_dm_rd);
      chk("if_stall", bus.if_stall, bus.if_req && !exp_ia);
      chk("dm_stall", bus.dm_stall, bus.dm_req && !exp_da);
    end
    bus.mem_ready = 1'b0;
    bus.mem_rdata = ret_fix ? ret_val : 32'($urandom);
    if (m_out && cyc == m_ready_c) begin
      bus.mem_ready = 1'b1;
      m_ret = bus.mem_rdata;
    end
  endtask

  task automatic drain();
    bus.if_req = 0;
    bus.dm_req = 0;
    for (int k = 0; k < 40 && m_out; k++) tick();
    chk("drain_tmo", m_out, 0);
    tick();
  endtask

  int  stores;
  bit  if_done;
  bit  if_gr;
  bit  dm_gr;
  int  exp_c[6] = '{1, 1, 1, 1, 0, 1};
  int  exp_b[2] = '{1, 0};

  initial begin
    reset = 1;
    bus.if_req = 0;
    bus.if_addr = '0;
    bus.dm_req = 0;
    bus.dm_we = 0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    bus.mem_ready = 0;
    bus.mem_rdata = '0;
    tick();
    tick();
    reset = 0;

    // single fetch, L=1
    fix_lat = 1;
    ret_fix = 1;
    ret_val = 32'hDEADBEEF;
    bus.if_req = 1;
    bus.if_addr = 32'h10;
    tick();
    chk("a_issue", bus.mem_req, 1);
    chk("a_addr", bus.mem_addr, 32'h10);
    chk("a_we", bus.mem_we, 0);
    tick();
    chk("a_wait_ack", bus.if_ack, 0);
    tick();
    chk("a_ack", bus.if_ack, 1);
    chk("a_rdata", bus.if_rdata, 32'hDEADBEEF);
    bus.if_req = 0;
    tick();
    chk("a_hold", bus.if_rdata, 32'hDEADBEEF);
    ret_fix = 0;
    fix_lat = 0;

    // simultaneous requests: data first
    g_log.delete();
    bus.if_req = 1;
    bus.if_addr = 32'h80;
    bus.dm_req = 1;
    bus.dm_we = 1;
    bus.dm_addr = 32'h40;
    bus.dm_wdata = 32'h5;
    tick();
    chk("b_we", bus.mem_we, 1);
    chk("b_wdata", bus.mem_wdata, 32'h5);
    chk("b_addr", bus.mem_addr, 32'h40);
    for (int k = 0; k < 40; k++) begin
      chk("b_stall", bus.if_stall, !bus.if_ack);
      if (bus.dm_ack) bus.dm_req = 0;
      if (bus.if_ack) break;
      tick();
    end
    chk("b_if_done", bus.if_ack, 1);
    bus.if_req = 0;
    chk("b_count", g_log.size(), 2);
    for (int i = 0; i < g_log.size() && i < 2; i++)
      chk("b_order", g_log[i], exp_b[i]);
    drain();

    // starvation cap with back-to-back stores
    g_log.delete();
    stores = 0;
    if_done = 0;
    bus.if_req = 1;
    bus.if_addr = 32'h100;
    bus.dm_req = 1;
    bus.dm_we = 1;
    bus.dm_addr = 32'h200;
    bus.dm_wdata = 32'h1000;
    for (int k = 0; k < 300 && !(if_done && stores == 5); k++) begin
      tick();
      if (bus.dm_ack) begin
        stores++;
        if (stores == 5) bus.dm_req = 0;
        else begin
          bus.dm_addr = 32'h200 + 32'(stores);
          bus.dm_wdata = 32'h1000 + 32'(stores);
        end
      end
      if (bus.if_ack) begin
        if_done = 1;
        bus.if_req = 0;
      end
    end
    chk("c_done", if_done && stores == 5, 1);
    chk("c_count", g_log.size(), 6);
    for (int i = 0; i < g_log.size() && i < 6; i++)
      chk("c_order", g_log[i], exp_c[i]);
    drain();

    // long memory latency L=7
    fix_lat = 7;
    bus.dm_req = 1;
    bus.dm_we = 0;
    bus.dm_addr = 32'h123;
    tick();
    chk("d_issue", bus.mem_req, 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("d_addr", bus.mem_addr, 32'h123);
      chk("d_we", bus.mem_we, 0);
      chk("d_noack", bus.dm_ack, 0);
      chk("d_nomreq", bus.mem_req, 0);
    end
    tick();
    chk("d_ack", bus.dm_ack, 1);
    bus.dm_req = 0;
    tick();
    chk("d_single", bus.dm_ack, 0);
    fix_lat = 0;

    // stray mem_ready while idle
    bus.mem_ready = 1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    chk("f_noack", bus.if_ack | bus.dm_ack, 0);
    chk("f_nomreq", bus.mem_req, 0);
    tick();

    // random traffic
    if_gr = 0;
    dm_gr = 0;
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (last_issue_c == cyc) begin
        if (m_own_dm) dm_gr = 1;
        else if_gr = 1;
      end
      if (last_ack_c == cyc && !m_own_dm) begin
        if_gr = 0;
        bus.if_req = ($urandom_range(0, 1) == 1);
        bus.if_addr = 32'($urandom);
      end else if (!bus.if_req && !if_gr) begin
        if ($urandom_range(0, 9) < 3) begin
          bus.if_req = 1;
          bus.if_addr = 32'($urandom);
        end
      end else if (if_gr && bus.if_req && $urandom_range(0, 9) == 0)
        bus.if_req = 0;
      if (last_ack_c == cyc && m_own_dm) begin
        dm_gr = 0;
        bus.dm_req = ($urandom_range(0, 1) == 1);
        bus.dm_we = ($urandom_range(0, 1) == 1);
        bus.dm_addr = 32'($urandom);
        bus.dm_wdata = 32'($urandom);
      end else if (!bus.dm_req && !dm_gr) begin
        if ($urandom_range(0, 9) < 4) begin
          bus.dm_req = 1;
          bus.dm_we = ($urandom_range(0, 1) == 1);
          bus.dm_addr = 32'($urandom);
          bus.dm_wdata = 32'($urandom);
        end
      end else if (dm_gr && bus.dm_req && $urandom_range(0, 9) == 0)
        bus.dm_req = 0;
      if (!m_out && $urandom_range(0, 19) == 0)
        bus.mem_ready = 1;
    end
    drain();

    // reset while waiting, late mem_ready afterwards
    fix_lat = 5;
    bus.if_req = 1;
    bus.if_addr = 32'h300;
    tick();
    chk("e_issue", bus.mem_req, 1);
    tick();
    reset = 1;
    bus.if_req = 0;
    tick();
    reset = 0;
    tick();
    bus.mem_ready = 1;
    bus.mem_rdata = 32'h12345678;
    tick();
    tick();
    chk("e_noack", bus.if_ack | bus.dm_ack, 0);
    chk("e_nomreq", bus.mem_req, 0);
    chk("e_if_rdata", bus.if_rdata, 0);
    chk("e_dm_rdata", bus.dm_rdata, 0);
    chk("e_addr", bus.mem_addr, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the number of consecutive data-side wins after which a waiting fetch request gets priority (legal range 1..15).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 if_req  input  1  SHALL be the fetch-stage read request, held with if_addr stable until if_ack.
REQ-005 if_addr  input  32  SHALL be the fetch word address (pc).
REQ-006 if_ack  output  1  SHALL be a one-cycle pulse marking fetch completion.
REQ-007 if_rdata  output  32  SHALL be the fetched instruction, valid while if_ack=1.
REQ-008 dm_req  input  1  SHALL be the memory-stage request, held with dm_we/dm_addr/dm_wdata stable until dm_ack.
REQ-009 dm_we  input  1  SHALL select write (1) or read (0) for the data request.
REQ-010 dm_addr  input  32  SHALL be the data word address (alu_result).
REQ-011 dm_wdata  input  32  SHALL be the store data.
REQ-012 dm_ack  output  1  SHALL be a one-cycle pulse marking data completion (reads and writes).
REQ-013 dm_rdata  output  32  SHALL be the load data, valid while dm_ack=1 and dm_we=1 was not set on that transaction.
REQ-014 mem_req  output  1  SHALL be a one-cycle issue strobe to the shared single-port memory.
REQ-015 mem_we, mem_addr[31:0], mem_wdata[31:0]  outputs  SHALL be the latched command, valid while mem_req=1 and held until mem_ready.
REQ-016 mem_ready  input  1  SHALL be the memory completion pulse; mem_rdata[31:0] input valid with it.
REQ-017 if_stall, dm_stall  outputs  1  SHALL be high whenever the respective req=1 and the matching ack=0 in that cycle (combinational, for pipeline freeze).

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one memory transaction outstanding at any time.
REQ-019 IDLE: if any req=1, SHALL latch winner's command and owner tag, go to ISSUE next cycle; else stay.
REQ-020 Arbitration SHALL grant dm when both request unless starve_cnt==STARVE_MAX, in which case if wins.
REQ-021 starve_cnt (4 bits) SHALL increment on a dm grant while if_req=1, clear on any if grant, hold otherwise; never exceeds STARVE_MAX.
REQ-022 ISSUE: mem_req=1 for exactly one cycle, then WAIT.
REQ-023 WAIT: on mem_ready=1, SHALL register mem_rdata into owner's rdata and go to RESP; else stay, command outputs held.
REQ-024 RESP: owner's ack=1 for one cycle, no new grant this cycle; next state IDLE.
REQ-025 Minimum latency SHALL be: req sampled at edge N -> mem_req cycle N+1 -> (mem_ready at cycle N+1+L, L>=1) -> ack cycle N+2+L.
REQ-026 mem_ready in IDLE, ISSUE or RESP SHALL be ignored with no state change.
REQ-027 A requester dropping req before ack SHALL NOT abort the transaction; ack still pulses in RESP.
REQ-028 if_rdata/dm_rdata SHALL hold last value outside ack cycles; mem_req/acks SHALL be 0 in all other states.

Reset
REQ-029 On reset=1 at an edge: state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0.
REQ-030 Reset during ISSUE/WAIT SHALL discard the outstanding transaction; a late mem_ready after reset SHALL produce no ack.

Verification
REQ-031 if_req=1, if_addr=0x10, dm_req=0, memory L=1 returns 0xDEADBEEF -> mem_req cycle 1, mem_addr=0x10, mem_we=0, if_ack cycle 3 with if_rdata=0xDEADBEEF.
REQ-032 if_req and dm_req (dm_we=1, addr 0x40, wdata 0x5) asserted together -> dm granted first (mem_we=1, mem_wdata=0x5), dm_ack then if served next; if_stall high throughout.
REQ-033 STARVE_MAX=4, dm_req held with 5 back-to-back stores, if_req held -> 4 dm grants, then if granted 5th, starve_cnt returns to 0, then remaining dm.
REQ-034 mem_ready delayed L=7 -> mem_addr/mem_we stable all 7 WAIT cycles, single ack pulse at cycle 9.
REQ-035 reset pulsed in WAIT, mem_ready arrives 2 cycles later -> no ack, state IDLE, all outputs at reset values.
REQ-036 Stray mem_ready in IDLE with no requests -> no ack, no state change, rdata unchanged.
